// File: rtl/id_scoreboard_issue.sv
// ID issue stage: IF/ID register plus per-register write-pending scoreboard for RAW stalls.
// Optional REGFILE_BYPASS_EN: write-through regfile, so pending writes clear one cycle earlier.
module id_scoreboard_issue #(
    parameter int unsigned WB_LAT   = 3,
    parameter int unsigned CNT_W    = 2,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] IF_inst,
    input  logic [31:0] IF_pc,
    input  logic        EX_br_sel,
    output logic        IF_stall,
    output logic [31:0] ID_inst,
    output logic [31:0] ID_pc,
    output logic        ID_issue,
    output logic [31:0] ID_sb_busy
);

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;

`ifdef REGFILE_BYPASS_EN
    localparam int unsigned LoadVal = WB_LAT - 1;
`else
    localparam int unsigned LoadVal = WB_LAT;
`endif
    localparam logic [CNT_W-1:0] LoadCnt = CNT_W'(LoadVal);
    localparam logic             LoadOn  = (LoadVal != 0);

    logic             valid_q;
    logic [31:0]      inst_q;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use_rs1;
    logic        use_rs2;
    logic        writes_rd;
    logic [31:0] busy;
    logic        hazard;
    logic        load_en;

    assign opcode = inst_q[6:0];
    assign rd     = inst_q[11:7];
    assign rs1    = inst_q[19:15];
    assign rs2    = inst_q[24:20];

    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OpReg: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
            end
            OpImm, OpLoad, OpJalr: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
            end
            OpStore, OpBranch: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OpLui, OpAuipc, OpJal: writes_rd = 1'b1;
            default: ;
        endcase
    end

    // x0 is never busy: its counter is never loaded and its bit is forced low.
    always_comb begin
        busy = '0;
        for (int r = 1; r < 32; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    assign hazard   = valid_q & ((use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2]));
    assign ID_issue = valid_q & ~hazard & ~EX_br_sel;
    assign IF_stall = valid_q & hazard & ~EX_br_sel;
    assign load_en  = ID_issue & writes_rd & (rd != 5'd0) & LoadOn;

    assign ID_inst    = inst_q;
    assign ID_pc      = pc_q;
    assign ID_sb_busy = busy;

    // A reload of a busy register overwrites its count (WAW); flushes never cancel entries.
    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if (load_en && (rd == 5'(r))) begin
                cnt_d[r] = LoadCnt;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            pc_q    <= '0;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            if (EX_br_sel) begin
                valid_q <= 1'b0;
                inst_q  <= NOP_INST;
            end else if (!IF_stall) begin
                valid_q <= 1'b1;
                inst_q  <= IF_inst;
                pc_q    <= IF_pc;
            end
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: tb/tb_id_scoreboard_issue.sv
// Randomized bench for id_scoreboard_issue against a ready-time model of register availability.
module tb_id_scoreboard_issue;

    localparam int unsigned WB_LAT   = 3;
    localparam int unsigned CNT_W    = 2;
    localparam logic [31:0] NOP_INST = 32'h00000013;
`ifdef REGFILE_BYPASS_EN
    localparam int LOAD = WB_LAT - 1;
`else
    localparam int LOAD = WB_LAT;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] IF_inst;
    logic [31:0] IF_pc;
    logic        EX_br_sel;
    logic        IF_stall;
    logic [31:0] ID_inst;
    logic [31:0] ID_pc;
    logic        ID_issue;
    logic [31:0] ID_sb_busy;

    always #5 i_clk = ~i_clk;

    id_scoreboard_issue #(
        .WB_LAT  (WB_LAT),
        .CNT_W   (CNT_W),
        .NOP_INST(NOP_INST)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .IF_inst   (IF_inst),
        .IF_pc     (IF_pc),
        .EX_br_sel (EX_br_sel),
        .IF_stall  (IF_stall),
        .ID_inst   (ID_inst),
        .ID_pc     (ID_pc),
        .ID_issue  (ID_issue),
        .ID_sb_busy(ID_sb_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: ID slot contents and, per register, the first cycle in which it may be read.
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    int          ready_at [32];
    int          cyc;
    logic        dut_stall_seen;

    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h73};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // {writes_rd, reads_rs2, reads_rs1}
    function automatic logic [2:0] decode(input logic [31:0] inst);
        case (inst[6:0])
            7'b0110011:                         return 3'b111;
            7'b0010011, 7'b0000011, 7'b1100111: return 3'b101;
            7'b0100011, 7'b1100011:             return 3'b011;
            7'b0110111, 7'b0010111, 7'b1101111: return 3'b100;
            default:                            return 3'b000;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_inst  = NOP_INST;
        m_pc    = '0;
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
    endtask

    // One cycle: drive inputs, check outputs against the model, then advance both on the edge.
    task automatic step(input logic [31:0] inst, input logic [31:0] pc, input logic br,
                        input logic rst);
        logic [31:0] eb;
        logic [2:0]  d;
        logic        haz;
        logic        e_issue;
        logic        e_stall;
        @(negedge i_clk);
        IF_inst   = inst;
        IF_pc     = pc;
        EX_br_sel = br;
        i_rst     = rst;
        #1;
        eb = '0;
        for (int r = 1; r < 32; r++) eb[r] = (ready_at[r] > cyc);
        d       = decode(m_inst);
        haz     = m_valid && ((d[0] && eb[m_inst[19:15]]) || (d[1] && eb[m_inst[24:20]]));
        e_issue = m_valid && !haz && !br;
        e_stall = m_valid && haz && !br;
        check_eq("issue", 32'(ID_issue), 32'(e_issue));
        check_eq("stall", 32'(IF_stall), 32'(e_stall));
        check_eq("busy", ID_sb_busy, eb);
        check_eq("inst", ID_inst, m_inst);
        if (m_valid) check_eq("pc", ID_pc, m_pc);
        dut_stall_seen = IF_stall;
        @(posedge i_clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e_issue && d[2] && m_inst[11:7] != 5'd0 && LOAD != 0)
                ready_at[m_inst[11:7]] = cyc + 1 + LOAD;
            if (br) begin
                m_valid = 1'b0;
                m_inst  = NOP_INST;
            end else if (!e_stall) begin
                m_valid = 1'b1;
                m_inst  = inst;
                m_pc    = pc;
            end
        end
        cyc++;
    endtask

    initial begin
        int          stalls;
        logic [31:0] inst;
        i_rst     = 1'b1;
        IF_inst   = NOP_INST;
        IF_pc     = '0;
        EX_br_sel = 1'b0;
        cyc       = 0;
        repeat (2) @(posedge i_clk);
        model_reset();

        // Reset state, then first capture after reset drops
        step(NOP_INST, 32'h0, 1'b0, 1'b1);
        step(NOP_INST, 32'h0, 1'b0, 1'b0);

        // RAW: addi x1 then add x2,x1,x1; count stall cycles seen on the DUT
        step(32'h00500093, 32'h100, 1'b0, 1'b0);
        step(32'h00108133, 32'h104, 1'b0, 1'b0);
        stalls = 0;
        for (int i = 0; i < LOAD + 2; i++) begin
            step(NOP_INST, 32'h108 + 32'(4 * i), 1'b0, 1'b0);
            stalls += int'(dut_stall_seen);
        end
        check_eq("raw_stall_cnt", 32'(stalls), 32'(LOAD));

        // x0 writes/reads and WAW reload by lui
        step(32'h00100013, 32'h200, 1'b0, 1'b0);
        step(32'h00000133, 32'h204, 1'b0, 1'b0);
        step(32'h00500093, 32'h208, 1'b0, 1'b0);
        step(32'h000020B7, 32'h20c, 1'b0, 1'b0);
        repeat (5) step(NOP_INST, 32'h210, 1'b0, 1'b0);

        // Flush while add is stalled
        step(32'h00500093, 32'h300, 1'b0, 1'b0);
        step(32'h00108133, 32'h304, 1'b0, 1'b0);
        step(NOP_INST, 32'h308, 1'b0, 1'b0);
        step(NOP_INST, 32'h30c, 1'b1, 1'b0);
        repeat (4) step(NOP_INST, 32'h310, 1'b0, 1'b0);

        // Flush overrides issue of a hazard-free writer
        step(32'h00300193, 32'h400, 1'b0, 1'b0);
        step(NOP_INST, 32'h404, 1'b1, 1'b0);
        repeat (2) step(NOP_INST, 32'h408, 1'b0, 1'b0);

        // Reset mid-countdown
        step(32'h00500093, 32'h500, 1'b0, 1'b0);
        step(NOP_INST, 32'h504, 1'b0, 1'b0);
        step(NOP_INST, 32'h508, 1'b0, 1'b1);
        repeat (2) step(NOP_INST, 32'h50c, 1'b0, 1'b0);

        // Random traffic on a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            inst        = $urandom;
            inst[6:0]   = ops[$urandom_range(0, 9)];
            inst[11:7]  = 5'($urandom_range(0, 3));
            inst[19:15] = 5'($urandom_range(0, 3));
            inst[24:20] = 5'($urandom_range(0, 3));
            step(inst, $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_scoreboard_issue.md
Name: id_scoreboard_issue

Overview:
- Decode-side issue stage of the non-forwarding 5-stage RV32I pipeline, directly downstream of the fetch stage.
- Holds the IF/ID pipeline register and a per-register write-pending scoreboard.
- Generates IF_stall when the instruction in ID reads a register whose producer has not yet written back.
- Drops wrong-path instructions when a branch or jump resolves taken in EX.

Parameters:
WB_LAT, 3, cycles from the issue edge until the producer's regfile write is complete (EX, MEM, WB); minimum 1
CNT_W, 2, scoreboard counter width; must satisfy 2**CNT_W > WB_LAT
NOP_INST, 32'h00000013, value driven on ID_inst when the ID slot is empty

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_rst  in  1  synchronous reset, active-high
IF_inst  in  32  fetched instruction; valid in the same cycle for IF_pc
IF_pc  in  32  fetch PC
EX_br_sel  in  1  taken branch or jump resolved in EX this cycle (flush)
IF_stall  out  1  hold PC and the IF/ID register (combinational)
ID_inst  out  32  instruction in ID (registered)
ID_pc  out  32  PC of the instruction in ID (registered)
ID_issue  out  1  ID instruction advances to EX this edge (combinational); 0 means the ID/EX register loads a bubble
ID_sb_busy  out  32  bit r = register r pending write; bit 0 is always 0

Behaviour:
- Reset (i_rst=1 at an edge): valid<=0, ID_inst<=NOP_INST, ID_pc<=0, all counters<=0. Resulting outputs: ID_issue=0, IF_stall=0, ID_sb_busy=0. Reset takes priority over every other event, including mid-stall and mid-countdown.
- Minimal decode on ID_inst[6:0]:
  - R-type 0110011: reads rs1 and rs2, writes rd.
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111: read rs1, write rd.
  - STORE 0100011, BRANCH 1100011: read rs1 and rs2, no write.
  - LUI 0110111, AUIPC 0010111, JAL 1101111: no reads, write rd.
  - Any other opcode: no reads, no write.
- Register x0 is never busy. A write with rd=x0 does not load a counter. A read of x0 never causes a hazard.
- Hazard = valid & ((use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2])), where busy[r] = (cnt[r] != 0).
- Combinational outputs:
  - ID_issue = valid & ~hazard & ~EX_br_sel
  - IF_stall = valid & hazard & ~EX_br_sel
- IF/ID register update, in priority order:
  - EX_br_sel=1: valid<=0, ID_inst<=NOP_INST. ID_pc is don't-care. The wrong-path IF_inst is discarded.
  - else IF_stall=1: hold all state.
  - else: capture IF_inst and IF_pc, valid<=1.
- Counter update, for each r != 0:
  - If ID_issue & writes_rd & rd==r: cnt[r]<=LOAD.
  - Else if cnt[r] != 0: cnt[r]<=cnt[r]-1.
  - LOAD = WB_LAT. A reload of an already-busy register (WAW) overwrites the old count.
- Flush never cancels scoreboard entries. The instruction in EX, including a JAL/JALR that writes rd, is valid and completes.
- Latency:
  - A consumer in ID the cycle after its producer issues stalls for LOAD cycles and issues in the following cycle.
  - Independent instructions issue back-to-back, one per cycle.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: the regfile is write-through, so a read in the WB cycle sees the new value. LOAD = WB_LAT-1. If LOAD=0, no counter is loaded and no RAW stall ever occurs.
- Undefined: LOAD = WB_LAT.

Test Plan:
- Reset: hold i_rst=1 for 2 cycles -> ID_issue=0, IF_stall=0, ID_inst=32'h00000013, ID_sb_busy=0. The first instruction is captured on the edge after i_rst drops.
- RAW: feed 0x00500093 (addi x1,x0,5) then 0x00108133 (add x2,x1,x1) -> IF_stall=1 for exactly 3 cycles, then add issues; ID_sb_busy[1] is set for 3 cycles after addi issues. With REGFILE_BYPASS_EN: 2 stall cycles.
- x0 and no-read cases: 0x00100013 (addi x0,x0,1) then 0x00000133 (add x2,x0,x0) -> no stall, ID_sb_busy[0]=0. 0x00500093 then 0x000020B7 (lui x1,2) -> no stall; ID_sb_busy[1] clears 3 cycles after lui issues (WAW reload).
- Flush during stall: while add x2,x1,x1 is stalled, pulse EX_br_sel=1 -> same cycle IF_stall=0, ID_issue=0. Next cycle ID_inst=0x00000013 and valid=0. cnt[1] keeps decrementing to 0.
- Flush priority: EX_br_sel=1 with a hazard-free instruction in ID -> ID_issue=0, no counter loaded for its rd.
- Reset mid-operation: ID_sb_busy[1]=1 with cnt=2, assert i_rst for one cycle -> next cycle ID_sb_busy=0 and valid=0.
